// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch.
// Time fields are 8-bit binary, hour/min/sec/frac.
package stopwatch_pkg;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] frac;
  } time_t;

  localparam logic [7:0] SEC_MAX  = 8'd59;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] HOUR_MAX = 8'd23;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  function automatic time_t time_inc(
    input time_t      t,
    input logic [7:0] frac_max
  );
    time_t n;
    n = t;
    if (t.frac != frac_max) begin
      n.frac = t.frac + 8'd1;
    end else begin
      n.frac = '0;
      if (t.sec != SEC_MAX) begin
        n.sec = t.sec + 8'd1;
      end else begin
        n.sec = '0;
        if (t.min != MIN_MAX) begin
          n.min = t.min + 8'd1;
        end else begin
          n.min = '0;
          if (t.hour != HOUR_MAX) begin
            n.hour = t.hour + 8'd1;
          end else begin
            n.hour = '0;
          end
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// First-word-fall-through lap store.
// Pop-and-push in one cycle is allowed even when full.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; clear wins.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage array, no reset needed: reads gated by empty.
  always_ff @(posedge clock) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch with hour wrap flag and lap capture.
// LAP_STOPWATCH_FIFO_EN: deep lap FIFO, else one register.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int MODE_ID   = 2,
  parameter int LAP_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     rezhim,
  input  logic                           button_start_stop,
  input  logic                           button_reset,
  input  logic                           button_lap,
  input  logic                           lap_rd,
  output logic [31:0]                    data_s,
  output logic                           running,
  output logic [31:0]                    lap_data,
  output logic                           lap_valid,
  output logic                           lap_full,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           overflow
);

  localparam int CW  = $clog2(LAP_DEPTH+1);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_TOP  = DW'(DIV-1);
  localparam logic [7:0]    FRAC_MAX = 8'(TICK_HZ-1);

  run_state_t    run_q;
  logic [DW-1:0] div_q, div_d;
  time_t         time_q, time_d;
  logic          ovf_q, ovf_d;

  logic btn_en;
  logic clr;
  logic ss;
  logic lap_push;
  logic tick;
  logic wrap;

  assign btn_en   = (rezhim == 2'(MODE_ID));
  assign clr      = btn_en && button_reset;
  assign ss       = btn_en && button_start_stop && !clr;
  assign lap_push = btn_en && button_lap && !clr
                    && (run_q == ST_RUN);

  assign tick = (run_q == ST_RUN) && (div_q == DIV_TOP);
  assign wrap = tick
                && time_q.hour == HOUR_MAX
                && time_q.min  == MIN_MAX
                && time_q.sec  == SEC_MAX
                && time_q.frac == FRAC_MAX;

  assign data_s   = time_q;
  assign running  = (run_q == ST_RUN);
  assign overflow = ovf_q;

  // Divider, time cascade and sticky overflow.
  always_comb begin
    div_d  = div_q;
    time_d = time_q;
    ovf_d  = ovf_q;
    if (clr) begin
      div_d  = '0;
      time_d = '0;
      ovf_d  = 1'b0;
    end else if (run_q == ST_RUN) begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) time_d = time_inc(time_q, FRAC_MAX);
      if (wrap) ovf_d = 1'b1;
    end
  end

  // Run state and counting registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q  <= ST_STOP;
      div_q  <= '0;
      time_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      time_q <= time_d;
      ovf_q  <= ovf_d;
      if (clr) begin
        run_q <= ST_STOP;
      end else if (ss) begin
        run_q <= (run_q == ST_RUN) ? ST_STOP : ST_RUN;
      end
    end
  end

`ifdef LAP_STOPWATCH_FIFO_EN

  logic lap_empty;

  lap_fifo #(
    .WIDTH (32),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clr),
    .push_i  (lap_push),
    .pop_i   (lap_rd),
    .data_i  (time_q),
    .data_o  (lap_data),
    .count_o (lap_count),
    .full_o  (lap_full),
    .empty_o (lap_empty)
  );

  assign lap_valid = !lap_empty;

`else

  logic [31:0] lap_q;
  logic        lap_v_q;

  // Single lap register: a push always overwrites.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lap_q   <= '0;
      lap_v_q <= 1'b0;
    end else if (clr) begin
      lap_q   <= '0;
      lap_v_q <= 1'b0;
    end else if (lap_push) begin
      lap_q   <= time_q;
      lap_v_q <= 1'b1;
    end else if (lap_rd) begin
      lap_v_q <= 1'b0;
    end
  end

  assign lap_data  = lap_v_q ? lap_q : '0;
  assign lap_valid = lap_v_q;
  assign lap_full  = lap_v_q;
  assign lap_count = CW'(lap_v_q);

`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch.
// Builds with or without LAP_STOPWATCH_FIFO_EN.
module tb_lap_stopwatch;

`ifdef LAP_STOPWATCH_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic        clock;
  logic        reset;
  logic [1:0]  rezhim;
  logic        button_start_stop;
  logic        button_reset;
  logic        button_lap;
  logic        lap_rd;
  logic [31:0] data_s;
  logic        running;
  logic [31:0] lap_data;
  logic        lap_valid;
  logic        lap_full;
  logic [3:0]  lap_count;
  logic        overflow;

  lap_stopwatch #(
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .MODE_ID   (2),
    .LAP_DEPTH (8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .rezhim            (rezhim),
    .button_start_stop (button_start_stop),
    .button_reset      (button_reset),
    .button_lap        (button_lap),
    .lap_rd            (lap_rd),
    .data_s            (data_s),
    .running           (running),
    .lap_data          (lap_data),
    .lap_valid         (lap_valid),
    .lap_full          (lap_full),
    .lap_count         (lap_count),
    .overflow          (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] rz;
    logic       ss;
    logic       rs;
    logic       lp;
    logic       rd;
    logic       run;
    int         cnt;
    logic       val;
  } vec_t;

  vec_t        tbl [12];
  int          n_pass;
  int          n_tot;
  int          ncyc;
  logic [31:0] q [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] tm(input int t);
    int s, m;
    s = t / 100;
    m = s / 60;
    return {8'((m / 60) % 24), 8'(m % 60),
            8'(s % 60), 8'(t % 100)};
  endfunction

  task automatic step(input logic [1:0] rz,
                      input logic ss, rs, lp, rd);
    rezhim            = rz;
    button_start_stop = ss;
    button_reset      = rs;
    button_lap        = lp;
    lap_rd            = rd;
    @(negedge clock);
    rezhim            = 2'd2;
    button_start_stop = 1'b0;
    button_reset      = 1'b0;
    button_lap        = 1'b0;
    lap_rd            = 1'b0;
    ncyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd2, 0, 0, 0, 0);
  endtask

  task automatic model_push(input logic [31:0] v);
`ifdef LAP_STOPWATCH_FIFO_EN
    if (q.size() < CAP) q.push_back(v);
`else
    q.delete();
    q.push_back(v);
`endif
  endtask

  // Lap while running; expected value from elapsed ticks.
  task automatic lap_step(input logic rd);
    logic [31:0] v;
    v = tm(ncyc / 10);
    step(2'd2, 0, 0, 1, rd);
    if (rd && q.size() > 0) void'(q.pop_front());
    model_push(v);
  endtask

  task automatic pop_step();
    step(2'd2, 0, 0, 0, 1);
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic chk_lap(input string nm);
    chk({nm, "_cnt"}, 32'(lap_count), 32'(q.size()));
    chk({nm, "_val"}, 32'(lap_valid), 32'(q.size() > 0));
    chk({nm, "_full"}, 32'(lap_full), 32'(q.size() == CAP));
    chk({nm, "_data"}, lap_data,
        (q.size() > 0) ? q[0] : 32'h0);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    ncyc   = 0;
    reset             = 1'b0;
    rezhim            = 2'd2;
    button_start_stop = 1'b0;
    button_reset      = 1'b0;
    button_lap        = 1'b0;
    lap_rd            = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_data", data_s, 32'h0);
    chk("rst_run", 32'(running), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk_lap("rst");
    reset = 1'b1;
    @(negedge clock);

    tbl[0]  = '{2'd1, 1, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{2'd2, 1, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{2'd2, 0, 0, 1, 0, 1, 1, 1};
    tbl[3]  = '{2'd1, 1, 1, 1, 0, 1, 1, 1};
    tbl[4]  = '{2'd0, 0, 0, 1, 0, 1, 1, 1};
    tbl[5]  = '{2'd0, 0, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{2'd2, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{2'd2, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{2'd2, 1, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{2'd2, 0, 0, 1, 1, 1, 1, 1};
    tbl[10] = '{2'd2, 1, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{2'd3, 1, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rz, tbl[i].ss, tbl[i].rs,
           tbl[i].lp, tbl[i].rd);
      chk($sformatf("vec%0d_run", i),
          32'(running), 32'(tbl[i].run));
      chk($sformatf("vec%0d_cnt", i),
          32'(lap_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_val", i),
          32'(lap_valid), 32'(tbl[i].val));
    end
    chk("vec_clr_data", data_s, 32'h0);
    chk("vec_clr_ovf", 32'(overflow), 32'h0);

    // One second of counting.
    step(2'd2, 0, 1, 0, 0);
    step(2'd2, 1, 0, 0, 0);
    ncyc = 0;
    idle(1000);
    chk("sec_data", data_s, 32'h0000_0100);
    chk("sec_run", 32'(running), 32'h1);
    step(2'd2, 1, 0, 0, 0);
    idle(5);
    chk("stop_hold", data_s, 32'h0000_0100);

    // Hour wrap from 23:59:59.99.
    step(2'd2, 0, 1, 0, 0);
    force dut.time_q = 32'h173B_3B63;
    idle(1);
    release dut.time_q;
    idle(1);
    chk("pre_data", data_s, 32'h173B_3B63);
    step(2'd2, 1, 0, 0, 0);
    idle(9);
    chk("pre_tick", data_s, 32'h173B_3B63);
    chk("pre_ovf", 32'(overflow), 32'h0);
    idle(1);
    chk("wrap_data", data_s, 32'h0);
    chk("wrap_ovf", 32'(overflow), 32'h1);
    step(2'd2, 1, 0, 0, 0);
    idle(3);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    step(2'd2, 0, 1, 0, 0);
    chk("ovf_clr", 32'(overflow), 32'h0);
    chk("ovf_clr_data", data_s, 32'h0);

    // Nine laps; storage overflow then drain.
    q.delete();
    step(2'd2, 1, 0, 0, 0);
    ncyc = 0;
    for (int i = 0; i < 9; i++) begin
      idle(11);
      lap_step(1'b0);
    end
    chk_lap("lap9");
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      chk_lap($sformatf("pop%0d", i));
      pop_step();
    end
    chk_lap("drained");
    pop_step();
    chk_lap("pop_empty");

    // Fill, then lap and pop together.
    for (int i = 0; i < CAP; i++) begin
      idle(11);
      lap_step(1'b0);
    end
    chk_lap("refill");
    idle(11);
    lap_step(1'b1);
    chk_lap("pushpop");
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      chk_lap($sformatf("pp_pop%0d", i));
      pop_step();
    end
    chk_lap("pp_drained");

    // Asynchronous reset mid-count.
    idle(37);
    #1 reset = 1'b0;
    #1;
    q.delete();
    chk("arst_data", data_s, 32'h0);
    chk("arst_run", 32'(running), 32'h0);
    chk("arst_ovf", 32'(overflow), 32'h0);
    chk_lap("arst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
